// File: rtl/zeroriscy_defines.sv
// Shared definitions for the zeroriscy EX-stage BNN unit: opcodes and FSM state encoding.
package zeroriscy_defines;

   localparam int BNN_OP_WIDTH = 3;

   localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_LDW   = 3'b000;
   localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_ACC   = 3'b001;
   localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_RDACC = 3'b010;
   localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_CLR   = 3'b011;
   localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_THR   = 3'b100;

   typedef enum logic {
      BNN_IDLE = 1'b0,
      BNN_BUSY = 1'b1
   } bnn_state_e;

endpackage

// File: rtl/zeroriscy_bnn_popcnt.sv
// Combinational population count over a W-bit slice.
module zeroriscy_bnn_popcnt #(
   parameter int W = 8
) (
   input  logic [W-1:0]           bits,
   output logic [$clog2(W):0]     count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + ($clog2(W)+1)'(bits[i]);
      end
   end

endmodule

// File: rtl/zeroriscy_bnn_xnor_acc.sv
// BNN XNOR-popcount accumulator on the EX enable/ready handshake.
// state    | meaning
// IDLE     | accepts a request; single-cycle ops finish in the request cycle
// BUSY     | ACC in progress, popcounting POP_BITS of the latched xnor per cycle
module zeroriscy_bnn_xnor_acc
   import zeroriscy_defines::*;
#(
   parameter int WDEPTH   = 8,
   parameter int POP_BITS = 8,
   parameter int ACC_W    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    bnn_en_i,
   input  logic [BNN_OP_WIDTH-1:0] bnn_operator_i,
   input  logic [31:0]             bnn_addr_i,
   input  logic [31:0]             bnn_data_i,
   output logic [31:0]             bnn_result_o,
   output logic                    bnn_ready_o
);

   localparam int N      = 32 / POP_BITS;
   localparam int IDX_W  = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;
   localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
   localparam int POP_W  = 6;
   localparam int PC_W   = $clog2(POP_BITS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   bnn_state_e              state;
   logic [31:0]             w [WDEPTH];
   logic [31:0]             xv;
   logic [CNT_W-1:0]        cnt;
   logic [POP_W-1:0]        pop;
   logic signed [ACC_W-1:0] acc;

   logic [IDX_W-1:0]        idx;
   logic [PC_W-1:0]         chunk_count;
   logic [POP_W-1:0]        pop_next;
   logic signed [7:0]       dot;
   logic signed [ACC_W:0]   sum;
   logic signed [ACC_W-1:0] acc_sat;
   logic                    unused_addr;

   assign idx         = bnn_addr_i[IDX_W-1:0];
   assign unused_addr = ^bnn_addr_i[31:IDX_W];

   zeroriscy_bnn_popcnt #(.W(POP_BITS)) u_popcnt (
      .bits  (xv[int'(cnt)*POP_BITS +: POP_BITS]),
      .count (chunk_count)
   );

   assign pop_next = pop + POP_W'(chunk_count);

   // One guard bit above ACC_W is enough since |dot| <= 32 and ACC_W >= 8.
   always_comb begin
      dot = $signed({1'b0, pop_next, 1'b0}) - 8'sd32;
      sum = {acc[ACC_W-1], acc} + {{(ACC_W-7){dot[7]}}, dot};
      if (sum[ACC_W] != sum[ACC_W-1]) begin
         acc_sat = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         acc_sat = sum[ACC_W-1:0];
      end
   end

   always_comb begin
      bnn_ready_o  = 1'b0;
      bnn_result_o = '0;
      if (!rst && bnn_en_i) begin
         if (state == BNN_IDLE) begin
            if (bnn_operator_i != BNN_OP_ACC) begin
               bnn_ready_o = 1'b1;
            end
            case (bnn_operator_i)
               BNN_OP_RDACC: bnn_result_o = 32'(acc);
               BNN_OP_THR:   bnn_result_o = {31'd0, ($signed(32'(acc)) >= $signed(bnn_data_i))};
               default:      bnn_result_o = '0;
            endcase
         end else if (cnt == CNT_LAST) begin
            bnn_ready_o  = 1'b1;
            bnn_result_o = 32'(acc_sat);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BNN_IDLE;
         acc   <= '0;
         cnt   <= '0;
         pop   <= '0;
         xv    <= '0;
         for (int i = 0; i < WDEPTH; i++) begin
            w[i] <= '0;
         end
      end else begin
         case (state)
            BNN_IDLE: begin
               if (bnn_en_i) begin
                  case (bnn_operator_i)
                     BNN_OP_LDW: w[idx] <= bnn_data_i;
                     BNN_OP_CLR: acc <= '0;
                     BNN_OP_ACC: begin
                        xv    <= ~(bnn_data_i ^ w[idx]);
                        cnt   <= '0;
                        pop   <= '0;
                        state <= BNN_BUSY;
                     end
                     default: ;
                  endcase
               end
            end
            BNN_BUSY: begin
               if (!bnn_en_i) begin
                  state <= BNN_IDLE;
               end else begin
                  pop <= pop_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST) begin
                     acc   <= acc_sat;
                     state <= BNN_IDLE;
                  end
               end
            end
            default: state <= BNN_IDLE;
         endcase
      end
   end

endmodule
